// File: rtl/gt_link_init_pkg.sv
// Shared types and constants for the GT link bring-up sequencer.
// The state encoding doubles as the 4-bit state_out probe value decoded by VIO/TB.
`timescale 1ns/1ps
package gt_link_init_pkg;

    localparam int unsigned STATE_W     = 4;
    localparam int unsigned RETRY_W     = 4;
    localparam int unsigned SYNC_STAGES = 2;

    localparam logic [STATE_W-1:0] STATE_RST_ALL   = 4'd0;
    localparam logic [STATE_W-1:0] STATE_WAIT_PG   = 4'd1;
    localparam logic [STATE_W-1:0] STATE_WAIT_TX   = 4'd2;
    localparam logic [STATE_W-1:0] STATE_WAIT_RX   = 4'd3;
    localparam logic [STATE_W-1:0] STATE_WAIT_BB   = 4'd4;
    localparam logic [STATE_W-1:0] STATE_WAIT_LINK = 4'd5;
    localparam logic [STATE_W-1:0] STATE_DONE      = 4'd6;
    localparam logic [STATE_W-1:0] STATE_RETRY_ALL = 4'd7;
    localparam logic [STATE_W-1:0] STATE_RETRY_RX  = 4'd8;
    localparam logic [STATE_W-1:0] STATE_RST_RX    = 4'd9;
    localparam logic [STATE_W-1:0] STATE_FAIL      = 4'd10;

    typedef enum logic [STATE_W-1:0] {
        ST_RST_ALL   = STATE_RST_ALL,
        ST_WAIT_PG   = STATE_WAIT_PG,
        ST_WAIT_TX   = STATE_WAIT_TX,
        ST_WAIT_RX   = STATE_WAIT_RX,
        ST_WAIT_BB   = STATE_WAIT_BB,
        ST_WAIT_LINK = STATE_WAIT_LINK,
        ST_DONE      = STATE_DONE,
        ST_RETRY_ALL = STATE_RETRY_ALL,
        ST_RETRY_RX  = STATE_RETRY_RX,
        ST_RST_RX    = STATE_RST_RX,
        ST_FAIL      = STATE_FAIL
    } state_e;

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous status bit.
`timescale 1ns/1ps
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/gt_link_init_ctrl.sv
// Autonomous bring-up/recovery sequencer for a single-lane GT wizard: drives the wizard
// resets, watches status with timeouts and retries, and honours VIO override requests.
`timescale 1ns/1ps
module gt_link_init_ctrl
    import gt_link_init_pkg::*;
#(
    parameter int unsigned RESET_PULSE_CYC = 16,
    parameter int unsigned TIMEOUT_CYC     = 2**20,
    parameter int unsigned LINK_STABLE_CYC = 4096,
    parameter int unsigned MAX_RETRIES     = 10
) (
    input  logic               hb_gtwiz_reset_clk_freerun_buf_int,
    input  logic               hb_gtwiz_reset_all_int,
    input  logic               gtpowergood_in,
    input  logic               gtwiz_reset_tx_done_in,
    input  logic               gtwiz_reset_rx_done_in,
    input  logic               gtwiz_buffbypass_rx_done_in,
    input  logic               gtwiz_buffbypass_rx_error_in,
    input  logic               link_status_in,
    input  logic               vio_reset_all_req,
    input  logic               vio_rx_datapath_req,
    input  logic               link_down_clear,
    output logic               gtwiz_reset_all_out,
    output logic               gtwiz_reset_tx_datapath_out,
    output logic               gtwiz_reset_rx_datapath_out,
    output logic               init_done_out,
    output logic [RETRY_W-1:0] init_retry_ctr_out,
    output logic               link_down_latched_out,
    output logic [STATE_W-1:0] state_out
);

    localparam int unsigned TMR_SPAN = (TIMEOUT_CYC > RESET_PULSE_CYC) ? TIMEOUT_CYC : RESET_PULSE_CYC;
    localparam int unsigned TMR_W    = $clog2(TMR_SPAN);
    localparam int unsigned STB_W    = $clog2(LINK_STABLE_CYC + 1);

    logic clk;
    logic rst;
    assign clk = hb_gtwiz_reset_clk_freerun_buf_int;
    assign rst = hb_gtwiz_reset_all_int;

    logic pg_s, tx_done_s, rx_done_s, bb_done_s, bb_err_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_pg (
        .clk(clk), .rst(rst), .d_in(gtpowergood_in), .q_out(pg_s)
    );
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_tx_done (
        .clk(clk), .rst(rst), .d_in(gtwiz_reset_tx_done_in), .q_out(tx_done_s)
    );
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_rx_done (
        .clk(clk), .rst(rst), .d_in(gtwiz_reset_rx_done_in), .q_out(rx_done_s)
    );
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_bb_done (
        .clk(clk), .rst(rst), .d_in(gtwiz_buffbypass_rx_done_in), .q_out(bb_done_s)
    );
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_bb_err (
        .clk(clk), .rst(rst), .d_in(gtwiz_buffbypass_rx_error_in), .q_out(bb_err_s)
    );

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [STB_W-1:0]   stab_q, stab_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               latched_q, latched_d;
    logic               reset_all_q, reset_all_d;
    logic               reset_rx_q, reset_rx_d;
    logic               restart;
    logic               timeout;
    logic               pulse_done;
    logic               stab_last;

    assign timeout    = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign pulse_done = (timer_q == TMR_W'(RESET_PULSE_CYC - 1));
    assign stab_last  = (stab_q == STB_W'(LINK_STABLE_CYC - 1));
    assign retry_inc  = sat_inc(retry_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        stab_d    = '0;
        retry_d   = retry_q;
        latched_d = latched_q & ~link_down_clear;
        restart   = 1'b0;

        case (state_q)
            ST_RST_ALL:   if (pulse_done) state_d = ST_WAIT_PG;
            ST_WAIT_PG: begin
                if (pg_s)         state_d = ST_WAIT_TX;
                else if (timeout) state_d = ST_RETRY_ALL;
            end
            ST_WAIT_TX: begin
                if (tx_done_s)    state_d = ST_WAIT_RX;
                else if (timeout) state_d = ST_RETRY_ALL;
            end
            ST_WAIT_RX: begin
                if (rx_done_s)    state_d = ST_WAIT_BB;
                else if (timeout) state_d = ST_RETRY_RX;
            end
            ST_WAIT_BB: begin
                if (bb_err_s)       state_d = ST_RETRY_RX;
                else if (bb_done_s) state_d = ST_WAIT_LINK;
                else if (timeout)   state_d = ST_RETRY_RX;
            end
            ST_WAIT_LINK: begin
                if (link_status_in) stab_d = stab_q + 1'b1;
                if (link_status_in && stab_last) state_d = ST_DONE;
                else if (timeout)                state_d = ST_RETRY_RX;
            end
            ST_DONE: begin
                if (!link_status_in || bb_err_s) begin
                    latched_d = 1'b1;
                    state_d   = ST_RST_RX;
                end
            end
            ST_RETRY_ALL, ST_RETRY_RX: begin
                retry_d = retry_inc;
                if (retry_inc >= RETRY_W'(MAX_RETRIES)) state_d = ST_FAIL;
                else if (state_q == ST_RETRY_ALL)        state_d = ST_RST_ALL;
                else                                     state_d = ST_RST_RX;
            end
            ST_RST_RX:    if (pulse_done) state_d = ST_WAIT_RX;
            ST_FAIL:      state_d = ST_FAIL;
            default:      state_d = ST_RST_ALL;
        endcase

        // Overrides pre-empt any retry bookkeeping above; re-requesting the same
        // reset state restarts its pulse timer.
        if (vio_reset_all_req) begin
            state_d = ST_RST_ALL;
            retry_d = '0;
            restart = 1'b1;
        end else if (vio_rx_datapath_req && state_q != ST_RST_ALL && state_q != ST_FAIL) begin
            state_d = ST_RST_RX;
            retry_d = retry_q;
            restart = 1'b1;
        end

        if (restart || state_d != state_q) begin
            timer_d = '0;
            stab_d  = '0;
        end

        reset_all_d = (state_q == ST_RST_ALL);
        reset_rx_d  = (state_q == ST_RST_RX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RST_ALL;
            timer_q     <= '0;
            stab_q      <= '0;
            retry_q     <= '0;
            latched_q   <= 1'b0;
            reset_all_q <= 1'b0;
            reset_rx_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            latched_q   <= latched_d;
            reset_all_q <= reset_all_d;
            reset_rx_q  <= reset_rx_d;
        end
    end

    assign gtwiz_reset_all_out         = reset_all_q;
    assign gtwiz_reset_tx_datapath_out = 1'b0;
    assign gtwiz_reset_rx_datapath_out = reset_rx_q;
    assign init_done_out               = (state_q == ST_DONE);
    assign init_retry_ctr_out          = retry_q;
    assign link_down_latched_out       = latched_q;
    assign state_out                   = state_q;

endmodule

// File: tb/tb_gt_link_init_ctrl.sv
// Self-checking bench for gt_link_init_ctrl with randomized status timing.
`timescale 1ns/1ps
module tb_gt_link_init_ctrl;
    import gt_link_init_pkg::*;

    localparam int P    = 4;
    localparam int T    = 64;
    localparam int L    = 8;
    localparam int M    = 3;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pg = 1'b0, tx_done = 1'b0, rx_done = 1'b0, bb_done = 1'b0, bb_err = 1'b0;
    logic       link = 1'b0, vio_all = 1'b0, vio_rx = 1'b0, clr = 1'b0;
    logic       reset_all, reset_tx, reset_rx, init_done, latched;
    logic [3:0] retry, state_out;

    int checks = 0;
    int errors = 0;
    int lat_pg = 0;
    int all_q[$];
    int rx_q[$];
    int all_run = 0;
    int rx_run = 0;
    int dwell[16];

    gt_link_init_ctrl #(
        .RESET_PULSE_CYC(P),
        .TIMEOUT_CYC(T),
        .LINK_STABLE_CYC(L),
        .MAX_RETRIES(M)
    ) dut (
        .hb_gtwiz_reset_clk_freerun_buf_int(clk),
        .hb_gtwiz_reset_all_int(rst),
        .gtpowergood_in(pg),
        .gtwiz_reset_tx_done_in(tx_done),
        .gtwiz_reset_rx_done_in(rx_done),
        .gtwiz_buffbypass_rx_done_in(bb_done),
        .gtwiz_buffbypass_rx_error_in(bb_err),
        .link_status_in(link),
        .vio_reset_all_req(vio_all),
        .vio_rx_datapath_req(vio_rx),
        .link_down_clear(clr),
        .gtwiz_reset_all_out(reset_all),
        .gtwiz_reset_tx_datapath_out(reset_tx),
        .gtwiz_reset_rx_datapath_out(reset_rx),
        .init_done_out(init_done),
        .init_retry_ctr_out(retry),
        .link_down_latched_out(latched),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Pulse-width recorder, per-state dwell counter and reset exclusivity watch.
    always @(negedge clk) begin
        if (rst) begin
            all_run = 0;
            rx_run  = 0;
        end else begin
            if (reset_all === 1'b1) all_run++;
            else if (all_run != 0) begin all_q.push_back(all_run); all_run = 0; end
            if (reset_rx === 1'b1) rx_run++;
            else if (rx_run != 0) begin rx_q.push_back(rx_run); rx_run = 0; end
            checks++;
            if (reset_tx !== 1'b0 || (reset_all === 1'b1 && reset_rx === 1'b1)) begin
                errors++;
                $display("FAIL reset_exclusive: all=%b tx=%b rx=%b required at most one, tx=0",
                         reset_all, reset_tx, reset_rx);
            end
        end
        if (!$isunknown(state_out)) dwell[state_out]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        all_q.delete();
        rx_q.delete();
        foreach (dwell[i]) dwell[i] = 0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string what);
        int n = 0;
        while (state_out !== s && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (state_out !== s) begin
            errors++;
            $display("FAIL %s: state %0d after %0d cycles, required %0d", what, state_out, n, s);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic bring_up(input logic link_v, input bit stop_bb);
        {pg, tx_done, rx_done, bb_done, bb_err, vio_all, vio_rx, clr} = '0;
        link = link_v;
        apply_reset();
        wait_state(STATE_WAIT_PG, 20, "enter_wait_pg");
        repeat ($urandom_range(0, 20)) step();
        pg = 1'b1;
        lat_pg = 0;
        while (state_out === STATE_WAIT_PG && lat_pg < 10) begin
            step();
            lat_pg++;
        end
        wait_state(STATE_WAIT_TX, 5, "enter_wait_tx");
        repeat ($urandom_range(0, 20)) step();
        tx_done = 1'b1;
        wait_state(STATE_WAIT_RX, 30, "enter_wait_rx");
        repeat ($urandom_range(0, 20)) step();
        rx_done = 1'b1;
        wait_state(STATE_WAIT_BB, 30, "enter_wait_bb");
        if (!stop_bb) begin
            repeat ($urandom_range(0, 20)) step();
            bb_done = 1'b1;
            wait_state(STATE_WAIT_LINK, 30, "enter_wait_link");
        end
    endtask

    task automatic test_reset();
        {pg, tx_done, rx_done, bb_done, bb_err, link, vio_all, vio_rx, clr} = '0;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (state_out !== STATE_RST_ALL) begin
            errors++; $display("FAIL reset_state: got %0d required %0d", state_out, STATE_RST_ALL);
        end
        checks++;
        if ({reset_all, reset_tx, reset_rx} !== 3'b000) begin
            errors++; $display("FAIL reset_outs: got %b required 000", {reset_all, reset_tx, reset_rx});
        end
        checks++;
        if ({init_done, latched, retry} !== 6'b0) begin
            errors++; $display("FAIL reset_status: done=%b latched=%b retry=%0d required 0/0/0",
                               init_done, latched, retry);
        end
    endtask

    task automatic test_happy_path();
        int w;
        bring_up(1'b1, 1'b0);
        wait_state(STATE_DONE, 40, "happy_done");
        w = (all_q.size() > 0) ? all_q[0] : -1;
        checks++;
        if (all_q.size() != 1 || w != P) begin
            errors++; $display("FAIL happy_reset_all_width: %0d pulses first %0d, required 1 pulse of %0d",
                               all_q.size(), w, P);
        end
        checks++;
        if (lat_pg != SYNC + 1) begin
            errors++; $display("FAIL happy_pg_latency: got %0d required %0d", lat_pg, SYNC + 1);
        end
        checks++;
        if (dwell[STATE_WAIT_LINK] != L) begin
            errors++; $display("FAIL happy_link_dwell: got %0d required %0d", dwell[STATE_WAIT_LINK], L);
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++; $display("FAIL happy_no_rx_reset: got %0d pulses required 0", rx_q.size());
        end
        checks++;
        if (init_done !== 1'b1 || retry !== 4'd0) begin
            errors++; $display("FAIL happy_done_status: done=%b retry=%0d required 1/0", init_done, retry);
        end
    endtask

    task automatic test_link_drop();
        int w;
        checks++;
        if (latched !== 1'b0) begin
            errors++; $display("FAIL drop_latched_init: got %b required 0", latched);
        end
        link = 1'b0;
        repeat ($urandom_range(1, 3)) begin
            step();
            if (rx_q.size() == 0 && all_q.size() <= 1) rx_q.delete();
        end
        link = 1'b1;
        checks++;
        if (latched !== 1'b1 || state_out !== STATE_RST_RX) begin
            errors++; $display("FAIL drop_reaction: latched=%b state=%0d required 1/%0d",
                               latched, state_out, STATE_RST_RX);
        end
        wait_state(STATE_DONE, 60, "drop_redone");
        w = (rx_q.size() > 0) ? rx_q[0] : -1;
        checks++;
        if (rx_q.size() != 1 || w != P) begin
            errors++; $display("FAIL drop_rx_width: %0d pulses first %0d, required 1 pulse of %0d",
                               rx_q.size(), w, P);
        end
        checks++;
        if (retry !== 4'd0 || latched !== 1'b1) begin
            errors++; $display("FAIL drop_after: retry=%0d latched=%b required 0/1", retry, latched);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (latched !== 1'b0) begin
            errors++; $display("FAIL drop_clear: got %b required 0", latched);
        end
        link = 1'b0;
        clr  = 1'b1;
        step();
        link = 1'b1;
        clr  = 1'b0;
        checks++;
        if (latched !== 1'b1) begin
            errors++; $display("FAIL drop_set_dominant: got %b required 1", latched);
        end
        wait_state(STATE_DONE, 60, "drop_redone2");
    endtask

    task automatic test_sync_reset_mid_link();
        bring_up(1'b0, 1'b0);
        repeat ($urandom_range(1, 30)) step();
        checks++;
        if (state_out !== STATE_WAIT_LINK) begin
            errors++; $display("FAIL midlink_state: got %0d required %0d", state_out, STATE_WAIT_LINK);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({state_out, reset_all, reset_tx, reset_rx, init_done, retry, latched} !== {STATE_RST_ALL, 9'b0}) begin
            errors++; $display("FAIL midlink_reset: state=%0d outs=%b%b%b done=%b retry=%0d latched=%b required all 0",
                               state_out, reset_all, reset_tx, reset_rx, init_done, retry, latched);
        end
        rst = 1'b0;
    endtask

    task automatic test_bb_both();
        int n = 0;
        bit saw_link = 1'b0;
        bring_up(1'b1, 1'b1);
        bb_done = 1'b1;
        bb_err  = 1'b1;
        while (state_out !== STATE_RETRY_RX && n < 10) begin
            step();
            n++;
            if (state_out === STATE_WAIT_LINK) saw_link = 1'b1;
        end
        checks++;
        if (state_out !== STATE_RETRY_RX || saw_link) begin
            errors++; $display("FAIL bb_both_retry: state=%0d saw_link=%0d required %0d/0",
                               state_out, saw_link, STATE_RETRY_RX);
        end
        step();
        bb_err = 1'b0;
        checks++;
        if (retry !== 4'd1 || state_out !== STATE_RST_RX) begin
            errors++; $display("FAIL bb_both_ctr: retry=%0d state=%0d required 1/%0d",
                               retry, state_out, STATE_RST_RX);
        end
        wait_state(STATE_DONE, 60, "bb_both_done");
        checks++;
        if (retry !== 4'd1) begin
            errors++; $display("FAIL bb_both_keep: retry=%0d required 1", retry);
        end
    endtask

    task automatic test_rx_timeout();
        int seq[$];
        int n = 0;
        logic [3:0] prev = 4'd0;
        bit ok = 1'b1;
        {bb_done, bb_err, vio_all, vio_rx, clr} = '0;
        pg = 1'b1; tx_done = 1'b1; rx_done = 1'b0; link = 1'b1;
        apply_reset();
        wait_state(STATE_WAIT_RX, 100, "tmo_enter_rx");
        clear_mon();
        while (state_out !== STATE_FAIL && n < 400) begin
            step();
            n++;
            if (retry !== prev) begin seq.push_back(int'(retry)); prev = retry; end
        end
        checks++;
        if (state_out !== STATE_FAIL) begin
            errors++; $display("FAIL tmo_fail: state=%0d required %0d", state_out, STATE_FAIL);
        end
        checks++;
        if (dwell[STATE_WAIT_RX] != M * T) begin
            errors++; $display("FAIL tmo_rx_dwell: got %0d required %0d", dwell[STATE_WAIT_RX], M * T);
        end
        if (seq.size() != M) ok = 1'b0;
        else foreach (seq[i]) if (seq[i] != i + 1) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tmo_retry_seq: got %p required 1..%0d", seq, M);
        end
        ok = (rx_q.size() == M - 1);
        foreach (rx_q[i]) if (rx_q[i] != P) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tmo_rx_pulses: got %p required %0d pulses of %0d", rx_q, M - 1, P);
        end
        vio_rx = 1'b1;
        repeat (T + 10) step();
        vio_rx = 1'b0;
        checks++;
        if (state_out !== STATE_FAIL || {reset_all, reset_rx, init_done} !== 3'b000) begin
            errors++; $display("FAIL tmo_fail_hold: state=%0d all=%b rx=%b done=%b required %0d/0/0/0",
                               state_out, reset_all, reset_rx, init_done, STATE_FAIL);
        end
    endtask

    task automatic test_fail_recover();
        int hold = $urandom_range(1, 6);
        int w;
        clear_mon();
        vio_all = 1'b1;
        step();
        checks++;
        if (state_out !== STATE_RST_ALL || retry !== 4'd0) begin
            errors++; $display("FAIL recover_vio: state=%0d retry=%0d required %0d/0",
                               state_out, retry, STATE_RST_ALL);
        end
        repeat (hold - 1) step();
        vio_all = 1'b0;
        wait_state(STATE_WAIT_PG, 20, "recover_pg");
        repeat (3) step();
        w = (all_q.size() > 0) ? all_q[0] : -1;
        checks++;
        if (all_q.size() != 1 || w != P + hold - 1) begin
            errors++; $display("FAIL recover_width: %0d pulses first %0d, required 1 pulse of %0d",
                               all_q.size(), w, P + hold - 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_happy_path();
        test_link_drop();
        test_sync_reset_mid_link();
        test_bb_both();
        test_rx_timeout();
        test_fail_recover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
